// File: rtl/mac_pkg.sv
// Shared definitions for the MAC-array matrix engine.
//   state_e      : sequencer states
//   MNT_*_IDX    : field index of M, N, T inside the packed {M,N,T} word
//                  (field i occupies mnt[i*DIM_W +: DIM_W])
//   DEF_*        : default dimension constants shared with the datapath
package mac_pkg;

  typedef enum logic [2:0] {
    IDLE, CHECK, LOAD, DRAIN, WRITE, DONE
  } state_e;

  localparam int MNT_T_IDX   = 0;
  localparam int MNT_N_IDX   = 1;
  localparam int MNT_M_IDX   = 2;

  localparam int DEF_DIM_W   = 4;
  localparam int DEF_MAX_DIM = 8;

endpackage

// File: rtl/mac_lat_pipe.sv
// Read-latency valid pipe: delays a one-bit strobe by DEPTH cycles.
//   clk, rst (async, active-high) : clock / reset
//   flush   : synchronous clear of all in-flight strobes
//   vld_in  : strobe entering the pipe
//   vld_out : strobe delayed by DEPTH cycles
module mac_lat_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic vld_in,
  output logic vld_out
);

  // vld_pipe[0] is the incoming strobe, vld_pipe[DEPTH] the delayed one.
  logic [DEPTH:1] vld_pipe;
  logic [DEPTH:0] vld_nxt;

  assign vld_nxt = {vld_pipe, vld_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        vld_pipe <= '0;
    else if (flush) vld_pipe <= '0;
    else            vld_pipe <= vld_nxt[DEPTH-1:0];
  end

  assign vld_out = vld_pipe[DEPTH];

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencer for the MAC-array matrix engine: C[MxT] = A[MxN] * B[NxT]
// as N outer-product steps followed by M row write-backs.
//   start/mnt/abort     : request interface, mnt = {M,N,T}
//   en_i/addr_i         : input SRAM read (column k of A)
//   en_w/addr_w         : weight SRAM read (row k of B)
//   acc_clr/acc_en      : accumulator control, acc_en aligned to read data
//   row_sel/col_mask    : datapath row select and active-lane mask
//   en_o/rw_o/addr_o    : output SRAM write-back
//   busy/done/err       : status
// Every output is decoded from registered state only.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int DIM_W   = DEF_DIM_W,
  parameter int MAX_DIM = DEF_MAX_DIM,
  parameter int AI_W    = 3,
  parameter int AW_W    = 3,
  parameter int AO_W    = 4,
  parameter int RD_LAT  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [3*DIM_W-1:0]         mnt,
  input  logic                       abort,
  output logic                       en_i,
  output logic [AI_W-1:0]            addr_i,
  output logic                       en_w,
  output logic [AW_W-1:0]            addr_w,
  output logic                       acc_clr,
  output logic                       acc_en,
  output logic [$clog2(MAX_DIM)-1:0] row_sel,
  output logic [MAX_DIM-1:0]         col_mask,
  output logic                       en_o,
  output logic                       rw_o,
  output logic [AO_W-1:0]            addr_o,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int CW   = $clog2(MAX_DIM + 1);
  localparam int RS_W = $clog2(MAX_DIM);
  localparam int DCW  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_e           state_q, state_d;
  logic [DIM_W-1:0] m_q, n_q, t_q;
  logic [CW-1:0]    k_q, mc_q;
  logic [DCW-1:0]   dr_q;
  logic             err_q;
  logic             dims_ok, k_last, m_last, kill;

  assign dims_ok = (m_q != '0) && (n_q != '0) && (t_q != '0) &&
                   (int'(m_q) <= MAX_DIM) && (int'(n_q) <= MAX_DIM) &&
                   (int'(t_q) <= MAX_DIM);
  assign k_last  = (int'(k_q) + 1 == int'(n_q));
  assign m_last  = (int'(mc_q) + 1 == int'(m_q));
  assign kill    = abort && (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    en_i     = 1'b0;
    en_w     = 1'b0;
    addr_i   = '0;
    addr_w   = '0;
    acc_clr  = 1'b0;
    row_sel  = '0;
    en_o     = 1'b0;
    rw_o     = 1'b0;
    addr_o   = '0;
    busy     = (state_q != IDLE);
    done     = 1'b0;
    for (int j = 0; j < MAX_DIM; j++)
      col_mask[j] = (state_q != IDLE) && (j < int'(t_q));
    unique case (state_q)
      IDLE:  if (start) state_d = CHECK;
      CHECK: begin
        acc_clr = dims_ok;
        state_d = dims_ok ? LOAD : DONE;
      end
      LOAD: begin
        en_i   = 1'b1;
        en_w   = 1'b1;
        addr_i = AI_W'(k_q);
        addr_w = AW_W'(k_q);
        if (k_last) state_d = DRAIN;
      end
      DRAIN: if (dr_q == '0) state_d = WRITE;
      WRITE: begin
        en_o    = 1'b1;
        rw_o    = 1'b1;
        addr_o  = AO_W'(mc_q);
        row_sel = RS_W'(mc_q);
        if (m_last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (kill) state_d = IDLE;
  end

  // Dims, counters and the sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q   <= '0;
      n_q   <= '0;
      t_q   <= '0;
      k_q   <= '0;
      mc_q  <= '0;
      dr_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        m_q <= mnt[MNT_M_IDX*DIM_W +: DIM_W];
        n_q <= mnt[MNT_N_IDX*DIM_W +: DIM_W];
        t_q <= mnt[MNT_T_IDX*DIM_W +: DIM_W];
      end
      if (state_q == CHECK) begin
        k_q  <= '0;
        mc_q <= '0;
        if (!abort) err_q <= !dims_ok;
      end
      if (state_q == LOAD) begin
        k_q  <= k_q + 1'b1;
        dr_q <= DCW'(RD_LAT - 1);
      end
      if (state_q == DRAIN && dr_q != '0) dr_q <= dr_q - 1'b1;
      if (state_q == WRITE) mc_q <= mc_q + 1'b1;
    end
  end

  assign err = err_q;

  // Each LOAD read strobe becomes an accumulate RD_LAT cycles later, when
  // the SRAM data reaches the array; abort drops strobes still in flight.
  mac_lat_pipe #(.DEPTH(RD_LAT)) u_lat_pipe (
    .clk     (clk),
    .rst     (rst),
    .flush   (kill),
    .vld_in  (state_q == LOAD),
    .vld_out (acc_en)
  );

endmodule

// File: tb/tb_mac_seq_ctrl.sv
module tb_mac_seq_ctrl;
  import mac_pkg::*;

  localparam int NC = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [11:0] mnt = '0;

  // RD_LAT = 1 instance (d1_*) and RD_LAT = 3 instance (d3_*)
  logic       d1_en_i, d1_en_w, d1_acc_clr, d1_acc_en, d1_en_o, d1_rw_o, d1_busy, d1_done, d1_err;
  logic [2:0] d1_addr_i, d1_addr_w, d1_row_sel;
  logic [3:0] d1_addr_o;
  logic [7:0] d1_col_mask;
  logic       d3_en_i, d3_en_w, d3_acc_clr, d3_acc_en, d3_en_o, d3_rw_o, d3_busy, d3_done, d3_err;
  logic [2:0] d3_addr_i, d3_addr_w, d3_row_sel;
  logic [3:0] d3_addr_o;
  logic [7:0] d3_col_mask;

  int checks = 0;
  int errors = 0;

  // per-cycle traces of one run, cycle 0 = start cycle
  logic       t_en_i[NC], t_en_w[NC], t_clr[NC], t_acc[NC], t_en_o[NC], t_rw_o[NC];
  logic       t_busy[NC], t_done[NC], t_err[NC];
  logic [2:0] t_ai[NC], t_aw[NC], t_rs[NC];
  logic [3:0] t_ao[NC];
  logic [7:0] t_cm[NC];
  logic       t3_acc[NC], t3_done[NC], t3_en_o[NC], t3_busy[NC];

  always #5 clk = ~clk;

  mac_seq_ctrl #(.RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .mnt(mnt), .abort(abort),
    .en_i(d1_en_i), .addr_i(d1_addr_i), .en_w(d1_en_w), .addr_w(d1_addr_w),
    .acc_clr(d1_acc_clr), .acc_en(d1_acc_en), .row_sel(d1_row_sel), .col_mask(d1_col_mask),
    .en_o(d1_en_o), .rw_o(d1_rw_o), .addr_o(d1_addr_o),
    .busy(d1_busy), .done(d1_done), .err(d1_err));

  mac_seq_ctrl #(.RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .mnt(mnt), .abort(abort),
    .en_i(d3_en_i), .addr_i(d3_addr_i), .en_w(d3_en_w), .addr_w(d3_addr_w),
    .acc_clr(d3_acc_clr), .acc_en(d3_acc_en), .row_sel(d3_row_sel), .col_mask(d3_col_mask),
    .en_o(d3_en_o), .rw_o(d3_rw_o), .addr_o(d3_addr_o),
    .busy(d3_busy), .done(d3_done), .err(d3_err));

  // Issue a start at cycle 0 (optionally with abort), optionally inject
  // start/abort/mnt at cycle inj_c, record ncyc cycles, then idle.
  task automatic run(input logic [11:0] mv, input int ncyc, input logic ab0,
                     input int inj_c, input logic inj_s, input logic inj_a,
                     input logic [11:0] inj_m);
    start = 1'b1; abort = ab0; mnt = mv;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0; mnt = 12'hFFF;
        if (c == inj_c) begin start = inj_s; abort = inj_a; mnt = inj_m; end
      end
      t_en_i[c] = d1_en_i;  t_en_w[c] = d1_en_w;  t_clr[c] = d1_acc_clr;
      t_acc[c]  = d1_acc_en; t_en_o[c] = d1_en_o; t_rw_o[c] = d1_rw_o;
      t_busy[c] = d1_busy;  t_done[c] = d1_done;  t_err[c] = d1_err;
      t_ai[c]   = d1_addr_i; t_aw[c]  = d1_addr_w; t_rs[c] = d1_row_sel;
      t_ao[c]   = d1_addr_o; t_cm[c]  = d1_col_mask;
      t3_acc[c] = d3_acc_en; t3_done[c] = d3_done; t3_en_o[c] = d3_en_o;
      t3_busy[c] = d3_busy;
    end
    start = 1'b0; abort = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #3;
    checks++;
    if ({d1_en_i, d1_en_w, d1_acc_clr, d1_acc_en, d1_en_o, d1_rw_o, d1_busy, d1_done, d1_err,
         d1_addr_i, d1_addr_w, d1_row_sel, d1_addr_o, d1_col_mask} !== '0) begin
      errors++; $display("FAIL reset_outputs d1 got nonzero outputs");
    end
    checks++;
    if ({d3_busy, d3_acc_en, d3_err, d3_col_mask} !== '0) begin
      errors++; $display("FAIL reset_outputs d3 got nonzero outputs");
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    run(12'h234, 12, 1'b0, -1, 1'b0, 1'b0, 12'h0);
    for (int c = 0; c < 12; c++) begin
      logic ld, wr;
      ld = (c >= 2 && c <= 4);
      wr = (c >= 6 && c <= 7);
      checks++;
      if (t_clr[c] !== (c == 1)) begin errors++; $display("FAIL basic_acc_clr cyc %0d got %b exp %b", c, t_clr[c], c == 1); end
      checks++;
      if (t_en_i[c] !== ld || t_en_w[c] !== ld) begin errors++; $display("FAIL basic_en_iw cyc %0d got %b%b exp %b", c, t_en_i[c], t_en_w[c], ld); end
      if (ld) begin
        checks++;
        if (t_ai[c] !== 3'(c - 2) || t_aw[c] !== 3'(c - 2)) begin errors++; $display("FAIL basic_addr_iw cyc %0d got %0d/%0d exp %0d", c, t_ai[c], t_aw[c], c - 2); end
      end
      checks++;
      if (t_acc[c] !== (c >= 3 && c <= 5)) begin errors++; $display("FAIL basic_acc_en cyc %0d got %b exp %b", c, t_acc[c], (c >= 3 && c <= 5)); end
      checks++;
      if (t_en_o[c] !== wr || t_rw_o[c] !== wr) begin errors++; $display("FAIL basic_en_o cyc %0d got %b%b exp %b", c, t_en_o[c], t_rw_o[c], wr); end
      if (wr) begin
        checks++;
        if (t_ao[c] !== 4'(c - 6) || t_rs[c] !== 3'(c - 6)) begin errors++; $display("FAIL basic_addr_o cyc %0d got %0d/%0d exp %0d", c, t_ao[c], t_rs[c], c - 6); end
      end
      checks++;
      if (t_done[c] !== (c == 8)) begin errors++; $display("FAIL basic_done cyc %0d got %b exp %b", c, t_done[c], c == 8); end
      checks++;
      if (t_busy[c] !== (c >= 1 && c <= 8)) begin errors++; $display("FAIL basic_busy cyc %0d got %b exp %b", c, t_busy[c], (c >= 1 && c <= 8)); end
      checks++;
      if (t_cm[c] !== ((c >= 1 && c <= 8) ? 8'h0F : 8'h00)) begin errors++; $display("FAIL basic_col_mask cyc %0d got %h", c, t_cm[c]); end
    end
  endtask

  task automatic test_illegal;
    logic [11:0] bad [2];
    bad[0] = 12'h033; bad[1] = 12'h911;
    for (int i = 0; i < 2; i++) begin
      run(bad[i], 8, 1'b0, -1, 1'b0, 1'b0, 12'h0);
      for (int c = 0; c < 8; c++) begin
        checks++;
        if (t_en_i[c] | t_en_w[c] | t_en_o[c] | t_acc[c] | t_clr[c]) begin errors++; $display("FAIL illegal_no_access mnt %h cyc %0d got enable", bad[i], c); end
        checks++;
        if (t_done[c] !== (c == 2)) begin errors++; $display("FAIL illegal_done mnt %h cyc %0d got %b exp %b", bad[i], c, t_done[c], c == 2); end
        checks++;
        if (t_busy[c] !== (c == 1 || c == 2)) begin errors++; $display("FAIL illegal_busy mnt %h cyc %0d got %b", bad[i], c, t_busy[c]); end
        if (c >= 2) begin
          checks++;
          if (t_err[c] !== 1'b1) begin errors++; $display("FAIL illegal_err mnt %h cyc %0d got %b exp 1", bad[i], c, t_err[c]); end
        end
      end
    end
    run(12'h111, 8, 1'b0, -1, 1'b0, 1'b0, 12'h0);
    checks++;
    if (t_err[1] !== 1'b1) begin errors++; $display("FAIL err_hold_in_check got %b exp 1", t_err[1]); end
    checks++;
    if (t_err[2] !== 1'b0 || t_err[7] !== 1'b0) begin errors++; $display("FAIL err_cleared got %b%b exp 00", t_err[2], t_err[7]); end
  endtask

  task automatic test_big;
    int n;
    run(12'h888, 26, 1'b0, -1, 1'b0, 1'b0, 12'h0);
    n = 0;
    for (int c = 0; c < 26; c++) n += int'(t3_acc[c]);
    checks++;
    if (n != 8) begin errors++; $display("FAIL big_acc_count got %0d exp 8", n); end
    checks++;
    if (t3_acc[4] !== 1'b0 || t3_acc[5] !== 1'b1 || t3_acc[12] !== 1'b1 || t3_acc[13] !== 1'b0) begin
      errors++; $display("FAIL big_acc_window got %b%b%b%b exp 0110", t3_acc[4], t3_acc[5], t3_acc[12], t3_acc[13]);
    end
    checks++;
    if (t3_en_o[12] !== 1'b0 || t3_en_o[13] !== 1'b1 || t3_en_o[20] !== 1'b1 || t3_en_o[21] !== 1'b0) begin
      errors++; $display("FAIL big_write_window got %b%b%b%b exp 0110", t3_en_o[12], t3_en_o[13], t3_en_o[20], t3_en_o[21]);
    end
    for (int c = 0; c < 26; c++) begin
      checks++;
      if (t3_done[c] !== (c == 21)) begin errors++; $display("FAIL big_done_lat3 cyc %0d got %b exp %b", c, t3_done[c], c == 21); end
    end
    checks++;
    if (t_done[19] !== 1'b1 || t_cm[1] !== 8'hFF) begin errors++; $display("FAIL big_lat1 got done %b mask %h exp 1 ff", t_done[19], t_cm[1]); end
  endtask

  task automatic test_start_while_busy;
    run(12'h234, 12, 1'b0, 3, 1'b1, 1'b0, 12'h555);
    for (int c = 2; c <= 4; c++) begin
      checks++;
      if (t_en_i[c] !== 1'b1 || t_ai[c] !== 3'(c - 2)) begin errors++; $display("FAIL busy_start_addr cyc %0d got %b/%0d exp 1/%0d", c, t_en_i[c], t_ai[c], c - 2); end
    end
    checks++;
    if (t_en_i[5] !== 1'b0 || t_en_o[6] !== 1'b1 || t_en_o[8] !== 1'b0 || t_cm[5] !== 8'h0F) begin
      errors++; $display("FAIL busy_start_dims got %b%b%b %h exp 010 0f", t_en_i[5], t_en_o[6], t_en_o[8], t_cm[5]);
    end
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (t_done[c] !== (c == 8)) begin errors++; $display("FAIL busy_start_done cyc %0d got %b exp %b", c, t_done[c], c == 8); end
    end
  endtask

  task automatic test_abort;
    run(12'h234, 12, 1'b0, 3, 1'b0, 1'b1, 12'h0);
    checks++;
    if (t_en_i[3] !== 1'b1 || t_ai[3] !== 3'd1 || t_acc[3] !== 1'b1) begin errors++; $display("FAIL abort_pre got %b/%0d/%b exp 1/1/1", t_en_i[3], t_ai[3], t_acc[3]); end
    checks++;
    if ({t_busy[4], t_en_i[4], t_en_w[4], t_acc[4], t_en_o[4], t_cm[4]} !== '0) begin errors++; $display("FAIL abort_idle got busy %b en %b acc %b mask %h exp 0", t_busy[4], t_en_i[4], t_acc[4], t_cm[4]); end
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (t_done[c] !== 1'b0 || t3_done[c] !== 1'b0 || t3_acc[c] !== 1'b0) begin errors++; $display("FAIL abort_no_done cyc %0d got done %b/%b acc3 %b exp 0", c, t_done[c], t3_done[c], t3_acc[c]); end
    end
    checks++;
    if (t_err[6] !== 1'b0) begin errors++; $display("FAIL abort_err got %b exp 0", t_err[6]); end
    // start wins over a coincident abort in IDLE
    run(12'h234, 12, 1'b1, -1, 1'b0, 1'b0, 12'h0);
    checks++;
    if (t_done[8] !== 1'b1 || t_busy[1] !== 1'b1) begin errors++; $display("FAIL abort_start_idle got done %b busy %b exp 1 1", t_done[8], t_busy[1]); end
  endtask

  task automatic test_single;
    int n;
    run(12'h111, 12, 1'b0, -1, 1'b0, 1'b0, 12'h0);
    n = 0;
    for (int c = 0; c < 12; c++) n += int'(t_en_i[c]) + int'(t_en_o[c]);
    checks++;
    if (n != 2 || t_en_i[2] !== 1'b1 || t_en_o[4] !== 1'b1 || t_ao[4] !== 4'd0) begin errors++; $display("FAIL single_access got count %0d en_i %b en_o %b exp 2 1 1", n, t_en_i[2], t_en_o[4]); end
    checks++;
    if (t_acc[3] !== 1'b1 || t_acc[2] !== 1'b0 || t_acc[4] !== 1'b0) begin errors++; $display("FAIL single_acc got %b%b%b exp 010", t_acc[2], t_acc[3], t_acc[4]); end
    checks++;
    if (t_done[5] !== 1'b1 || t_done[4] !== 1'b0 || t_cm[3] !== 8'h01) begin errors++; $display("FAIL single_done got %b%b mask %h exp 01 01", t_done[4], t_done[5], t_cm[3]); end
    checks++;
    if (t3_done[7] !== 1'b1 || t3_done[6] !== 1'b0 || t3_acc[5] !== 1'b1) begin errors++; $display("FAIL single_lat3 got done %b%b acc %b exp 01 1", t3_done[6], t3_done[7], t3_acc[5]); end
  endtask

  task automatic test_rst_write;
    logic saw_done;
    start = 1'b1; mnt = 12'h234;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (d1_en_o !== 1'b1) begin errors++; $display("FAIL rst_pre_write got en_o %b exp 1", d1_en_o); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({d1_en_i, d1_en_w, d1_acc_clr, d1_acc_en, d1_en_o, d1_rw_o, d1_busy, d1_done, d1_err,
         d1_addr_i, d1_addr_w, d1_row_sel, d1_addr_o, d1_col_mask} !== '0) begin
      errors++; $display("FAIL rst_mid_write got nonzero outputs");
    end
    @(negedge clk); rst = 1'b0;
    saw_done = 1'b0;
    repeat (6) begin @(posedge clk); #1; saw_done |= d1_done | d1_busy; end
    checks++;
    if (saw_done !== 1'b0) begin errors++; $display("FAIL rst_no_done got activity %b exp 0", saw_done); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_illegal;
    test_big;
    test_start_while_busy;
    test_abort;
    test_single;
    test_rst_write;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Parametrised sequencer for the MAC-array matrix engine: computes C[M×T] = A[M×N]·B[N×T] as N outer-product steps, then writes M result rows back.
- Sits between the top-level START/MNT interface, the input, weight and output SRAMs, and the MAC datapath.
- Generates memory enables and addresses, and the accumulator clear/enable timed to SRAM read latency.
- Generates the row-select and column-mask signals for the datapath, plus busy/done/err status.

Parameters:
- DIM_W, 4: width of each of the M, N, T fields in mnt.
- MAX_DIM, 8: largest legal value of M, N and T; also the array lane count.
- AI_W, 3: input SRAM address width. Requires 2^AI_W >= MAX_DIM.
- AW_W, 3: weight SRAM address width. Requires 2^AW_W >= MAX_DIM.
- AO_W, 4: output SRAM address width. Requires 2^AO_W >= MAX_DIM.
- RD_LAT, 1: SRAM read latency in cycles, 1..3.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-high.
- start, in, 1: single-cycle start request.
- mnt, in, 3*DIM_W: {M,N,T}, sampled only on an accepted start.
- abort, in, 1: synchronous cancel.
- en_i, out, 1: input SRAM read enable.
- addr_i, out, AI_W: input SRAM address (column k of A).
- en_w, out, 1: weight SRAM read enable.
- addr_w, out, AW_W: weight SRAM address (row k of B).
- acc_clr, out, 1: clear all accumulators.
- acc_en, out, 1: accumulate the current outer product.
- row_sel, out, $clog2(MAX_DIM): datapath row driven onto the output SRAM write data.
- col_mask, out, MAX_DIM: bit j = (j < T); unused lanes are zeroed.
- en_o, out, 1: output SRAM enable.
- rw_o, out, 1: 1 = write.
- addr_o, out, AO_W: output SRAM address.
- busy, out, 1: operation in progress.
- done, out, 1: one-cycle completion pulse.
- err, out, 1: last request had an illegal dimension.

Behaviour:
- Reset state:
  - Async rst forces IDLE and clears all counters and latched dims.
  - All outputs are 0 in reset, except err, which also resets to 0.
  - All outputs are decoded from registered state and counters only; no combinational input→output path.
- States and transitions:
  - IDLE → CHECK on start. mnt is latched into M, N, T at that edge.
  - CHECK (1 cycle): if any of M, N, T is 0 or exceeds MAX_DIM, set err=1 and go to DONE with no memory access. Otherwise clear err, assert acc_clr=1, set k=0, and go to LOAD.
  - LOAD (N cycles): en_i=en_w=1, addr_i=addr_w=k, k increments each cycle. Go to DRAIN after k=N-1.
  - DRAIN (RD_LAT cycles): no enables. A drain counter counts down RD_LAT.
  - WRITE (M cycles): en_o=1, rw_o=1, addr_o=m, row_sel=m, m=0..M-1. Go to DONE after m=M-1.
  - DONE (1 cycle): done=1, then go to IDLE.
- busy: 1 in every state except IDLE.
- Accumulate timing:
  - A RD_LAT-deep valid shift register delays the LOAD read strobe.
  - acc_en=1 exactly RD_LAT cycles after each LOAD cycle, giving exactly N pulses.
  - The last acc_en falls in the final DRAIN cycle, so WRITE sees the fully accumulated result.
- Latency: start accepted at cycle 0 gives done at cycle 1+N+RD_LAT+M+1 for legal dims, and at cycle 2 for illegal dims.
- col_mask: held constant from CHECK through DONE. It is 0 in IDLE.
- start while busy: ignored, and latched dims are unchanged.
- abort:
  - When asserted in any busy state: next cycle is IDLE, all enables deassert, no done pulse, err unchanged.
  - abort in IDLE has no effect.
  - If abort and start are asserted together in IDLE, start wins.
- Reset mid-operation: returns to IDLE immediately. No done pulse; the SRAM contents are undefined.
- Counter widths:
  - k and m use $clog2(MAX_DIM+1) bits, so no wrap is possible.
  - Addresses are zero-extended to the port widths.

Decomposition:
- Shared package mac_pkg holds:
  - the state enum (IDLE, CHECK, LOAD, DRAIN, WRITE, DONE);
  - the MNT field offsets;
  - the default MAX_DIM/DIM_W constants, reused by the datapath and the top level.
- One sub-module, mac_lat_pipe: a RD_LAT-deep valid shift register with async clear, which produces acc_en.

Test Plan:
- M=2, N=3, T=4, RD_LAT=1, start at cycle 0:
  - acc_clr at cycle 1; en_i/en_w with addr 0,1,2 at cycles 2-4; acc_en at cycles 3-5.
  - en_o/rw_o with addr_o 0,1 at cycles 6-7; done at cycle 8.
  - col_mask=8'h0F; busy high during cycles 1-8.
- mnt={0,3,3}, then {9,1,1}: err=1 and done at cycle 2, with no en_i/en_w/en_o. A following legal run clears err.
- RD_LAT=3, M=N=T=8: exactly 8 acc_en pulses, the last one in the final DRAIN cycle; done at cycle 21.
- start pulsed again during LOAD with different mnt: ignored; addresses and done timing match the first request.
- abort in the second LOAD cycle: IDLE next cycle, all enables 0, no done. rst during WRITE: all outputs 0 immediately.
- M=N=T=1: single read, single write, done at cycle 1+1+RD_LAT+1+1.
